// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-port (A: CPU data, B: loader/debug) arbiter onto one memory
//            port, with bus-lock ownership and 1-cycle read-return routing.
//            Define MEM_ARB_RR_EN for round-robin IDLE arbitration (default:
//            port A fixed priority).
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ALEN     = 32,
    parameter int XLEN     = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic            a_lock,
    input  logic            a_we,
    input  logic [ALEN-1:0] a_addr,
    input  logic [XLEN-1:0] a_wdata,
    input  logic [3:0]      a_be,
    input  logic [2:0]      a_funct3,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [XLEN-1:0] a_rdata,
    input  logic            b_req,
    input  logic            b_lock,
    input  logic            b_we,
    input  logic [ALEN-1:0] b_addr,
    input  logic [XLEN-1:0] b_wdata,
    input  logic [3:0]      b_be,
    input  logic [2:0]      b_funct3,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [XLEN-1:0] b_rdata,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    // The entry grant is the first of MAX_LOCK; owned-state grants count from 1.
    localparam logic [7:0] c_lock_last = 8'(MAX_LOCK - 1);

    state_t     r_state;
    logic       r_ptr;          // 0: A wins contention, 1: B wins
    logic [7:0] r_lock_cnt;
    logic       r_rv_a;
    logic       r_rv_b;

    logic       w_gnt_a;
    logic       w_gnt_b;
    logic [7:0] w_cnt_next;

    assign w_cnt_next = r_lock_cnt + 8'd1;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (a_req && b_req) begin
                        w_gnt_a = ~r_ptr;
                        w_gnt_b = r_ptr;
                    end else begin
                        w_gnt_a = a_req;
                        w_gnt_b = b_req;
                    end
                end
                ST_OWN_A: w_gnt_a = a_req;
                ST_OWN_B: w_gnt_b = b_req;
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_rv_a     <= 1'b0;
            r_rv_b     <= 1'b0;
        end else begin
            r_rv_a <= w_gnt_a & ~a_we;
            r_rv_b <= w_gnt_b & ~b_we;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_a || w_gnt_b) begin
`ifdef MEM_ARB_RR_EN
                        r_ptr <= w_gnt_a;
`else
                        r_ptr <= 1'b0;
`endif
                        if (w_gnt_a && a_lock) begin
                            r_state    <= ST_OWN_A;
                            r_lock_cnt <= 8'd0;
                        end else if (w_gnt_b && b_lock) begin
                            r_state    <= ST_OWN_B;
                            r_lock_cnt <= 8'd0;
                        end
                    end
                end
                ST_OWN_A: begin
                    if (w_gnt_a) begin
                        r_lock_cnt <= w_cnt_next;
                        if (!a_lock) begin
                            r_state <= ST_IDLE;
                        end else if (w_cnt_next == c_lock_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= 1'b1;
                        end
                    end else if (!a_lock) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWN_B: begin
                    if (w_gnt_b) begin
                        r_lock_cnt <= w_cnt_next;
                        if (!b_lock) begin
                            r_state <= ST_IDLE;
                        end else if (w_cnt_next == c_lock_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= 1'b0;
                        end
                    end else if (!b_lock) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_be     = 4'd0;
        mem_funct3 = 3'd0;
        if (w_gnt_a) begin
            mem_addr   = a_addr;
            mem_wdata  = a_wdata;
            mem_we     = a_we;
            mem_be     = a_be;
            mem_funct3 = a_funct3;
        end else if (w_gnt_b) begin
            mem_addr   = b_addr;
            mem_wdata  = b_wdata;
            mem_we     = b_we;
            mem_be     = b_be;
            mem_funct3 = b_funct3;
        end
    end

    assign a_gnt    = w_gnt_a;
    assign b_gnt    = w_gnt_b;
    assign a_rvalid = r_rv_a;
    assign b_rvalid = r_rv_b;
    assign a_rdata  = r_rv_a ? mem_rdata : '0;
    assign b_rdata  = r_rv_b ? mem_rdata : '0;

endmodule
`default_nettype wire
